// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler: owns the state register and round counter and
// drives one shared combinational round datapath once per cycle for NR rounds.
`timescale 1ns/1ps
module aes_round_sched #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         abort,
  output logic         busy,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e       fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q,  st_d;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path leaves it unassigned and no latch is inferred.
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    if (abort) begin
      fsm_d = IDLE;
      rnd_d = 4'd0;
      st_d  = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          // Round-0 whitening happens here rather than through the shared datapath.
          if (in_valid) begin
            st_d  = in_data ^ rk_data;
            rnd_d = 4'd1;
            fsm_d = ROUND;
          end
        end
        ROUND: begin
          st_d = dp_result;
          if (rnd_q == NR_L) fsm_d = DONE;
          else               rnd_d = rnd_q + 4'd1;
        end
        DONE: begin
          if (out_ready) begin
            fsm_d = IDLE;
            rnd_d = 4'd0;
          end
        end
        default: begin
          fsm_d = IDLE;
          rnd_d = 4'd0;
        end
      endcase
    end
  end

  // NOTE: the 128-bit state is a handful of flops, not a memory, so it is reset along with the control state; out_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  // Moore decodes only: no input reaches in_ready or out_valid combinationally.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = st_q;
  assign dp_state  = st_q;
  assign rk_idx    = (fsm_q == ROUND) ? rnd_q : 4'd0;
  assign dp_last   = (fsm_q == ROUND) && (rnd_q == NR_L);

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: models the key store and round datapath, and checks
// ciphertext and handshake timing against a round-by-round AES-128 reference.
`timescale 1ns/1ps
module tb_aes_round_sched;

  localparam int NR0 = 10;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, abort, busy, dp_last;
  logic [127:0] in_data, out_data, rk_data, dp_state, dp_result;
  logic [3:0]   rk_idx;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, abort1, busy1, dp_last1;
  logic [127:0] in_data1, out_data1, rk_data1, dp_state1, dp_result1;
  logic [3:0]   rk_idx1;

  int checks = 0;
  int errors = 0;

  logic [127:0] rk [16];

  // ---------------- reference AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p = x; inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr + 4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, rk[r], r == nr);
    return s;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rcon = 8'h01;
    for (int i = 4; i < 64; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- environment: key store and round datapath ----------------
  assign rk_data    = rk[rk_idx];
  assign dp_result  = aes_round(dp_state, rk_data, dp_last);
  assign rk_data1   = rk[rk_idx1];
  assign dp_result1 = aes_round(dp_state1, rk_data1, dp_last1);

  aes_round_sched #(.NR(NR0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .abort(abort),
    .busy(busy), .rk_idx(rk_idx), .rk_data(rk_data), .dp_state(dp_state),
    .dp_last(dp_last), .dp_result(dp_result)
  );

  aes_round_sched #(.NR(1)) u_dut_nr1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .abort(abort1),
    .busy(busy1), .rk_idx(rk_idx1), .rk_data(rk_data1), .dp_state(dp_state1),
    .dp_last(dp_last1), .dp_result(dp_result1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && in_ready !== 1'b1; i++) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: in_ready=%b, required 1 within 64 cycles", in_ready);
    end
  endtask

  // One block through the NR=10 instance with out_ready high; checks timing and result.
  task automatic encrypt_block(input string tag, input logic [127:0] pt, input logic [127:0] exp);
    int  last_cnt;
    bit  seq_ok;
    last_cnt = 0; seq_ok = 1'b1;
    wait_idle();
    in_data = pt; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (rk_idx !== 4'd0 || dp_last !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_cycle: rk_idx=%0d dp_last=%b, required 0 0", tag, rk_idx, dp_last);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= NR0; k++) begin
      if (rk_idx !== 4'(k) || dp_last !== (k == NR0) || out_valid !== 1'b0 || busy !== 1'b1) begin
        seq_ok = 1'b0;
        $display("  %s cycle %0d: rk_idx=%0d dp_last=%b out_valid=%b busy=%b", tag, k, rk_idx,
                 dp_last, out_valid, busy);
      end
      if (dp_last === 1'b1) last_cnt++;
      tick();
    end
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s round_seq: sequence wrong, required rk_idx 1..%0d with dp_last on last only", tag, NR0);
    end
    checks++;
    if (last_cnt != 1) begin
      errors++;
      $display("FAIL %s dp_last_count: got %0d, required 1", tag, last_cnt);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid_latency: out_valid=%b %0d cycles after accept, required 1", tag, out_valid, NR0 + 1);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s out_data: got %h, required %h", tag, out_data, exp);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: in_ready=%b out_valid=%b, required 1 0", tag, in_ready, out_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 ||
        rk_idx !== 4'd0 || dp_state !== '0 || dp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h rk_idx=%0d dp_last=%b, required 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_data, rk_idx, dp_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    set_key(FIPS_KEY);
    encrypt_block("fips", FIPS_PT, FIPS_CT);
  endtask

  task automatic test_random();
    logic [127:0] pt;
    for (int n = 0; n < 6; n++) begin
      set_key(rand128());
      pt = rand128();
      encrypt_block($sformatf("random%0d", n), pt, model_encrypt(pt, NR0));
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    bit           ok;
    set_key(FIPS_KEY);
    wait_idle();
    in_data = FIPS_PT; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NR0; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== FIPS_CT) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, FIPS_CT);
    end
    held = out_data; ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand128();
      tick();
      if (out_data !== held || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: out_data=%h in_ready=%b busy=%b, required %h 0 1", out_data, in_ready, busy, held);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int           acc [$];
    logic [127:0] outs [$];
    set_key(FIPS_KEY);
    wait_idle();
    in_data = FIPS_PT; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (acc.size() == 2) in_valid = 1'b0;
      if (in_valid && in_ready) acc.push_back(cyc);
      if (out_valid && out_ready) outs.push_back(out_data);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc.size() != 2 || acc[1] - acc[0] != NR0 + 2) begin
      errors++;
      $display("FAIL b2b_spacing: %0d accepts, spacing %0d, required 2 accepts %0d apart",
               acc.size(), (acc.size() == 2) ? acc[1] - acc[0] : -1, NR0 + 2);
    end
    checks++;
    if (outs.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, required 2", outs.size());
    end
    foreach (outs[i]) begin
      checks++;
      if (outs[i] !== FIPS_CT) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h, required %h", i, outs[i], FIPS_CT);
      end
    end
  endtask

  task automatic test_abort();
    bit seen;
    set_key(FIPS_KEY);
    wait_idle();
    in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16 && rk_idx !== 4'd5; i++) tick();
    checks++;
    if (rk_idx !== 4'd5) begin
      errors++;
      $display("FAIL abort_reach: rk_idx=%0d, required 5", rk_idx);
    end
    abort = 1'b1; in_valid = 1'b1; in_data = FIPS_PT;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 ||
        dp_state !== '0 || rk_idx !== 4'd0) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b out_data=%h rk_idx=%0d, required 1 0 0 0 0",
               in_ready, out_valid, busy, out_data, rk_idx);
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_output: out_valid=1 seen, required 0");
    end
    encrypt_block("after_abort", FIPS_PT, FIPS_CT);
  endtask

  task automatic test_async_reset();
    set_key(FIPS_KEY);
    wait_idle();
    in_data = FIPS_PT; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 ||
        rk_idx !== 4'd0 || dp_state !== '0 || dp_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b busy=%b out_data=%h rk_idx=%0d, required 1 0 0 0",
               in_ready, busy, out_data, rk_idx);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_valid: busy=%b, required 0", busy);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    encrypt_block("after_reset", FIPS_PT, FIPS_CT);
  endtask

  task automatic test_nr1();
    logic [127:0] pt, exp;
    set_key(rand128());
    pt  = rand128();
    exp = model_encrypt(pt, 1);
    in_data1 = pt; in_valid1 = 1'b1; out_ready1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1 || rk_idx1 !== 4'd0) begin
      errors++;
      $display("FAIL nr1_idle: in_ready=%b rk_idx=%0d, required 1 0", in_ready1, rk_idx1);
    end
    tick();
    in_valid1 = 1'b0;
    checks++;
    if (rk_idx1 !== 4'd1 || dp_last1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL nr1_round: rk_idx=%0d dp_last=%b out_valid=%b, required 1 1 0", rk_idx1, dp_last1, out_valid1);
    end
    tick();
    checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== exp) begin
      errors++;
      $display("FAIL nr1_out: out_valid=%b out_data=%h, required 1 %h", out_valid1, out_data1, exp);
    end
    tick();
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL nr1_idle_after: in_ready=%b out_valid=%b, required 1 0", in_ready1, out_valid1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0; in_data = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; abort1 = 1'b0; in_data1 = '0;
    set_key(FIPS_KEY);
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_nr1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
